s2mm_ring_scheduler: RTL
========================

S2MM_RING_SCHEDULER -- requirements
Module: s2mm_ring_scheduler

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 64: byte address width of the ring base and the issued command address.
REQ-002 SHALL have parameter C_PTR_WIDTH, default 32: width of ring offsets and ring size.
REQ-003 SHALL have parameter C_CHUNK_SIZE, default 4096: bytes per issued command; power of two, at most 65535.
REQ-004 SHALL have ports clk (in, 1: sole clock) and rst_n (in, 1: asynchronous active-low reset); there is one clock, and reset is asynchronous and active-low.
REQ-005 SHALL have port enable (in, 1): run request, level-sensitive.
REQ-006 SHALL have port buf_base (in, C_AXI_ADDR_WIDTH): ring base byte address.
REQ-007 SHALL have port buf_size (in, C_PTR_WIDTH): ring size in bytes, a nonzero multiple of C_CHUNK_SIZE.
REQ-008 SHALL have port rd_ptr (in, C_PTR_WIDTH): software consume offset, in bytes from base.
REQ-009 SHALL have ports m_axis_ctl_tdata (out, C_AXI_ADDR_WIDTH+16), m_axis_ctl_tvalid (out, 1) and m_axis_ctl_tready (in, 1): command to the S2MM engine, where [C_AXI_ADDR_WIDTH+15:16] is the address and [15:0] is the byte length.
REQ-010 SHALL have ports s_axis_st_tdata (in, 8), s_axis_st_tvalid (in, 1) and s_axis_st_tready (out, 1): completion status, where [1:0] is the worst BRESP and [7:2] is reserved.
REQ-011 SHALL have port wr_ptr (out, C_PTR_WIDTH): produce offset in bytes.
REQ-012 SHALL have ports irq (out, 1: one-cycle pulse per completed chunk), error (out, 1: sticky error flag) and busy (out, 1: state not IDLE).

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT_ST, DRAIN and HALT.
REQ-014 SHALL, in IDLE with enable=1 and error=0, latch buf_base and buf_size into internal registers and take the ISSUE/WAIT path only while free > C_CHUNK_SIZE.
REQ-015 SHALL compute free = buf_size - ((wr_ptr - rd_ptr) mod buf_size), using C_PTR_WIDTH+1-bit arithmetic; wr_ptr == rd_ptr means empty.
REQ-016 SHALL require strict ">" in the free test, so the ring never becomes completely full.
REQ-017 SHALL, in ISSUE, hold m_axis_ctl_tvalid=1 with tdata = {base_latched + wr_ptr, C_CHUNK_SIZE[15:0]} stable until tready.
REQ-018 SHALL go ISSUE -> WAIT_ST on the ctl handshake.
REQ-019 SHALL drive s_axis_st_tready=1 only in WAIT_ST and DRAIN, and hold it 0 in all other states.
REQ-020 SHALL, on a status handshake with [1:0]==0, advance wr_ptr by C_CHUNK_SIZE (to 0 when the sum equals buf_size), pulse irq in the following cycle, and go WAIT_ST -> IDLE.
REQ-021 SHALL, on a status handshake with [1:0]!=0, set error, leave wr_ptr unchanged, give no irq, and go -> HALT.
REQ-022 SHALL, when enable drops in ISSUE before the handshake, deassert tvalid and go -> IDLE (no command issued); when enable drops in WAIT_ST, go -> DRAIN.
REQ-023 SHALL, in DRAIN, consume the pending status with the same wr_ptr/irq/error rules, then go -> IDLE (or -> HALT on error).
REQ-024 SHALL keep HALT until enable=0, then clear error and go -> IDLE.
REQ-025 SHALL allow at most one outstanding command.
REQ-026 SHALL ignore status beats arriving in IDLE/ISSUE (tready=0); this is a protocol violation by the upstream engine.
REQ-027 SHALL sample rd_ptr every cycle with no latching; an rd_ptr outside [0, buf_size) is undefined.
REQ-028 SHALL take an enable rise during DRAIN effect only after returning to IDLE.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, wr_ptr=0, m_axis_ctl_tvalid=0, s_axis_st_tready=0, irq=0, error=0, busy=0, and clear the latched base/size.
REQ-030 SHALL make a mid-transfer reset abandon any outstanding command; the S2MM engine is reset on the same rst_n.

Structure
REQ-031 SHALL place the state encoding and the ctl field offsets (address LSB = 16, length width = 16) in a shared package, and the BRESP OKAY constant in the same package.
REQ-032 SHALL isolate the free-space computation in a sub-module ring_space_calc, which is purely combinational.
REQ-033 SHALL keep the design single-module otherwise, targeting roughly 150-250 RTL lines.

Verification
REQ-034 SHALL cover basic issue: base=0x1000_0000, size=0x4000, rd=0, enable=1 -> ctl tdata addr=0x1000_0000, len=0x1000; status 0x00 -> wr_ptr=0x1000, one irq pulse.
REQ-035 SHALL cover wrap and full: rd=0x1000, wr reaching 0x3000 -> next addr 0x1000_3000, then wr_ptr=0x0000; further issue is blocked (free=0x1000, not > chunk) until rd advances to 0x2000.
REQ-036 SHALL cover error: status 0x02 -> error=1, wr_ptr unchanged, no irq, no new command; enable=0 -> error=0, IDLE.
REQ-037 SHALL cover disable in WAIT_ST: enable=0 after the ctl handshake, status 0x00 ten cycles later -> wr_ptr advances, irq pulses, busy=0, no further command.
REQ-038 SHALL cover backpressure: tready held low for 20 cycles -> tvalid and tdata stable throughout; enable=0 at cycle 10 -> tvalid=0 the next cycle, wr_ptr unchanged.
REQ-039 SHALL cover async reset in WAIT_ST: rst_n low for 1 cycle -> all outputs reach their reset values immediately (asynchronously), and wr_ptr=0.

Source files
------------

// File: rtl/s2mm_ring_scheduler_pkg.sv
// Shared definitions for the S2MM ring scheduler: FSM encoding, command
// field layout and write-response codes.
package s2mm_ring_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_ST = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    // Command word layout: {address, length}; the address starts at bit 16.
    localparam int CTL_ADDR_LSB = 16;
    localparam int CTL_LEN_W    = 16;

    // AXI write response code for a clean completion.
    localparam logic [1:0] BRESP_OKAY = 2'b00;

    // True when the worst-case BRESP reported by the engine is OKAY.
    function automatic logic bresp_is_okay(input logic [1:0] bresp);
        return (bresp == BRESP_OKAY);
    endfunction

endpackage

// File: rtl/ring_space_calc.sv
// Free space in a byte ring: size - ((wr - rd) mod size). Purely
// combinational; one extra bit keeps the borrow of wr - rd visible.
module ring_space_calc #(
    parameter int C_PTR_WIDTH = 32
) (
    input  logic [C_PTR_WIDTH-1:0] size_i,
    input  logic [C_PTR_WIDTH-1:0] wr_ptr_i,
    input  logic [C_PTR_WIDTH-1:0] rd_ptr_i,
    output logic [C_PTR_WIDTH:0]   free_o
);

    logic [C_PTR_WIDTH:0] diff_s;
    logic [C_PTR_WIDTH:0] used_s;

    // Occupancy with wrap-around, then the remaining free bytes.
    always_comb begin
        diff_s = {1'b0, wr_ptr_i} - {1'b0, rd_ptr_i};
        if (diff_s[C_PTR_WIDTH]) begin
            // Producer has wrapped behind the consumer: add one ring length.
            used_s = diff_s + {1'b0, size_i};
        end else begin
            used_s = diff_s;
        end
        free_o = {1'b0, size_i} - used_s;
    end

endmodule

// File: rtl/s2mm_ring_scheduler.sv
// Issues fixed-size S2MM write commands into a software-consumed byte ring,
// one command in flight at a time, and advances the produce pointer on
// each clean completion.
module s2mm_ring_scheduler
    import s2mm_ring_scheduler_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 64,
    parameter int C_PTR_WIDTH      = 32,
    parameter int C_CHUNK_SIZE     = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   buf_base,
    input  logic [C_PTR_WIDTH-1:0]        buf_size,
    input  logic [C_PTR_WIDTH-1:0]        rd_ptr,
    output logic [C_AXI_ADDR_WIDTH+15:0]  m_axis_ctl_tdata,
    output logic                          m_axis_ctl_tvalid,
    input  logic                          m_axis_ctl_tready,
    input  logic [7:0]                    s_axis_st_tdata,
    input  logic                          s_axis_st_tvalid,
    output logic                          s_axis_st_tready,
    output logic [C_PTR_WIDTH-1:0]        wr_ptr,
    output logic                          irq,
    output logic                          error,
    output logic                          busy
);

    localparam logic [C_PTR_WIDTH:0]   CHUNK_P   = (C_PTR_WIDTH + 1)'(C_CHUNK_SIZE);
    localparam logic [CTL_LEN_W-1:0]   CHUNK_LEN = CTL_LEN_W'(C_CHUNK_SIZE);

    state_e                        state_q;
    logic [C_PTR_WIDTH-1:0]        size_q;
    logic [C_PTR_WIDTH-1:0]        wr_ptr_q;
    // Holds the latched ring base already offset by the produce pointer.
    logic [C_AXI_ADDR_WIDTH-1:0]   ctl_addr_q;
    logic                          ctl_tvalid_q;
    logic                          st_tready_q;
    logic                          irq_q;
    logic                          error_q;
    logic                          busy_q;

    logic [C_PTR_WIDTH:0]          free_s;
    logic [C_PTR_WIDTH:0]          wr_sum_s;
    logic [C_PTR_WIDTH-1:0]        wr_ptr_d;
    logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr_s;
    logic                          st_hs_s;
    logic                          st_ok_s;
    logic                          unused_st_s;

    // Free space is only consulted in IDLE, where the live ring size is
    // the value being latched on the same edge.
    ring_space_calc #(
        .C_PTR_WIDTH (C_PTR_WIDTH)
    ) u_space (
        .size_i   (buf_size),
        .wr_ptr_i (wr_ptr_q),
        .rd_ptr_i (rd_ptr),
        .free_o   (free_s)
    );

    assign st_hs_s     = s_axis_st_tvalid & st_tready_q;
    assign st_ok_s     = bresp_is_okay(s_axis_st_tdata[1:0]);
    assign cmd_addr_s  = buf_base + C_AXI_ADDR_WIDTH'(wr_ptr_q);
    // Upper status bits are reserved and carry no meaning here.
    assign unused_st_s = ^s_axis_st_tdata[7:2];

    // Next produce offset after a clean chunk, wrapping at the ring end.
    always_comb begin
        wr_sum_s = {1'b0, wr_ptr_q} + CHUNK_P;
        if (wr_sum_s == {1'b0, size_q}) begin
            wr_ptr_d = {C_PTR_WIDTH{1'b0}};
        end else begin
            wr_ptr_d = wr_sum_s[C_PTR_WIDTH-1:0];
        end
    end

    // Scheduler FSM with all handshake and status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            size_q       <= {C_PTR_WIDTH{1'b0}};
            wr_ptr_q     <= {C_PTR_WIDTH{1'b0}};
            ctl_addr_q   <= {C_AXI_ADDR_WIDTH{1'b0}};
            ctl_tvalid_q <= 1'b0;
            st_tready_q  <= 1'b0;
            irq_q        <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && !error_q) begin
                        size_q <= buf_size;
                        // Strict compare: one chunk always stays empty so a
                        // full ring is never confused with an empty one.
                        if (free_s > CHUNK_P) begin
                            ctl_addr_q   <= cmd_addr_s;
                            ctl_tvalid_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (m_axis_ctl_tready) begin
                        ctl_tvalid_q <= 1'b0;
                        st_tready_q  <= 1'b1;
                        state_q      <= ST_WAIT_ST;
                    end else if (!enable) begin
                        // Withdraw the command before it was accepted.
                        ctl_tvalid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_WAIT_ST, ST_DRAIN: begin
                    if (st_hs_s) begin
                        st_tready_q <= 1'b0;
                        if (st_ok_s) begin
                            wr_ptr_q <= wr_ptr_d;
                            irq_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            error_q  <= 1'b1;
                            state_q  <= ST_HALT;
                        end
                    end else if ((state_q == ST_WAIT_ST) && !enable) begin
                        // The engine still owes a status; keep accepting it.
                        state_q <= ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    if (!enable) begin
                        error_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ctl_tvalid_q <= 1'b0;
                    st_tready_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_ctl_tdata  = {ctl_addr_q, CHUNK_LEN};
    assign m_axis_ctl_tvalid = ctl_tvalid_q;
    assign s_axis_st_tready  = st_tready_q;
    assign wr_ptr            = wr_ptr_q;
    assign irq               = irq_q;
    assign error             = error_q;
    assign busy              = busy_q;

endmodule
